// File: rtl/vm2002_pkg.sv
// Shared types and coin valuation for the vending machine controller.
package vm2002_pkg;

    typedef enum logic [2:0] {
        COIN_NONE,
        COIN_NICKEL,
        COIN_DIME,
        COIN_QUARTER,
        COIN_DOLLAR
    } coin_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_VEND,
        ST_CHANGE
    } state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CREDIT,
        S_VENDED,
        S_NO_STOCK,
        S_LOW_FUNDS,
        S_REFUND,
        S_RESTOCK_ERR
    } status_t;

    function automatic logic [6:0] coin_value(input coin_t c);
        case (c)
            COIN_NICKEL:  return 7'd5;
            COIN_DIME:    return 7'd10;
            COIN_QUARTER: return 7'd25;
            COIN_DOLLAR:  return 7'd100;
            default:      return 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_inventory.sv
// Per-lane stock and price storage with a checked restock write port,
// a combinational read port and a single-unit decrement port.
module vend_inventory #(
    parameter int N_ITEMS    = 8,
    parameter int SLOT_DEPTH = 16,
    parameter int COST_W     = 16,
    parameter int IDX_W      = $clog2(N_ITEMS),
    parameter int CNT_W      = $clog2(SLOT_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_item,
    input  logic [CNT_W-1:0]  wr_count,
    input  logic [COST_W-1:0] wr_cost,
    output logic              wr_err,
    input  logic [IDX_W-1:0]  rd_item,
    output logic [CNT_W-1:0]  rd_stock,
    output logic [COST_W-1:0] rd_cost,
    input  logic              dec_en,
    input  logic [IDX_W-1:0]  dec_item
);

    logic [CNT_W-1:0]  stock [N_ITEMS];
    logic [COST_W-1:0] cost  [N_ITEMS];
    logic [CNT_W:0]    wr_sum;

    // One spare bit so an overfull lane is detected rather than wrapped.
    assign wr_sum   = {1'b0, stock[wr_item]} + {1'b0, wr_count};
    assign wr_err   = wr_sum > (CNT_W + 1)'(SLOT_DEPTH);
    assign rd_stock = stock[rd_item];
    assign rd_cost  = cost[rd_item];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                stock[i] <= '0;
                cost[i]  <= '0;
            end
        end else begin
            if (wr_en && !wr_err) begin
                stock[wr_item] <= wr_sum[CNT_W-1:0];
                cost[wr_item]  <= wr_cost;
            end
            if (dec_en) begin
                stock[dec_item] <= stock[dec_item] - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: coin credit, lane selection, dispense and change.
// state is exported so the FSM can be observed alongside status.
module vend_ctrl
    import vm2002_pkg::*;
#(
    parameter  int N_ITEMS    = 8,
    parameter  int SLOT_DEPTH = 16,
    parameter  int COST_W     = 16,
    localparam int IDX_W      = $clog2(N_ITEMS),
    localparam int CNT_W      = $clog2(SLOT_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  coin_t             coin,
    input  logic              sel_valid,
    input  logic [IDX_W-1:0]  sel_item,
    input  logic              cancel,
    input  logic              sup_valid,
    input  logic [IDX_W-1:0]  sup_item,
    input  logic [CNT_W-1:0]  sup_count,
    input  logic [COST_W-1:0] sup_cost,
    output logic              sup_ready,
    output logic              vend_valid,
    output logic [IDX_W-1:0]  vend_item,
    output logic              change_valid,
    output logic [COST_W-1:0] change_amt,
    output logic              coin_reject,
    output logic [COST_W-1:0] balance,
    output status_t           status,
    output state_t            state
);

    logic [IDX_W-1:0]  lane;
    logic [IDX_W-1:0]  rd_item;
    logic [CNT_W-1:0]  rd_stock;
    logic [COST_W-1:0] rd_cost;
    logic              wr_err;
    logic [COST_W-1:0] coin_val;
    logic [COST_W:0]   coin_sum;
    logic              coin_ok;
    logic              coin_take;
    logic              coin_rej;

    assign coin_val  = COST_W'(coin_value(coin));
    assign coin_sum  = {1'b0, balance} + {1'b0, coin_val};
    // A coin is only taken when nothing else competes for the balance this cycle.
    assign coin_ok   = (state == ST_IDLE || state == ST_CREDIT) && !sel_valid
                       && !cancel && !coin_sum[COST_W];
    assign coin_take = (coin != COIN_NONE) && coin_ok;
    assign coin_rej  = (coin != COIN_NONE) && !coin_ok;
    assign sup_ready = sup_valid && (state == ST_IDLE);
    assign rd_item   = (state == ST_VEND) ? lane : sel_item;

    vend_inventory #(
        .N_ITEMS    (N_ITEMS),
        .SLOT_DEPTH (SLOT_DEPTH),
        .COST_W     (COST_W),
        .IDX_W      (IDX_W),
        .CNT_W      (CNT_W)
    ) u_inv (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (sup_ready),
        .wr_item  (sup_item),
        .wr_count (sup_count),
        .wr_cost  (sup_cost),
        .wr_err   (wr_err),
        .rd_item  (rd_item),
        .rd_stock (rd_stock),
        .rd_cost  (rd_cost),
        .dec_en   (state == ST_VEND),
        .dec_item (lane)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            balance      <= '0;
            lane         <= '0;
            status       <= S_IDLE;
            vend_valid   <= 1'b0;
            vend_item    <= '0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            coin_reject  <= 1'b0;
        end else begin
            vend_valid   <= 1'b0;
            vend_item    <= '0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            coin_reject  <= coin_rej;
            if (sup_ready) status <= wr_err ? S_RESTOCK_ERR : S_IDLE;
            if (coin_take) balance <= coin_sum[COST_W-1:0];
            case (state)
                ST_IDLE: begin
                    if (coin_take) begin
                        state  <= ST_CREDIT;
                        status <= S_CREDIT;
                    end
                end
                ST_CREDIT: begin
                    if (cancel) begin
                        state        <= ST_CHANGE;
                        change_valid <= 1'b1;
                        change_amt   <= balance;
                        status       <= S_REFUND;
                    end else if (sel_valid) begin
                        if (rd_stock == '0 || rd_cost == '0) begin
                            status <= S_NO_STOCK;
                        end else if (balance < rd_cost) begin
                            status <= S_LOW_FUNDS;
                        end else begin
                            lane       <= sel_item;
                            state      <= ST_VEND;
                            vend_valid <= 1'b1;
                            vend_item  <= sel_item;
                            status     <= S_VENDED;
                        end
                    end else if (coin_take) begin
                        status <= S_CREDIT;
                    end
                end
                ST_VEND: begin
                    // The refund pulse carries the post-purchase balance.
                    balance      <= balance - rd_cost;
                    change_valid <= 1'b1;
                    change_amt   <= balance - rd_cost;
                    state        <= ST_CHANGE;
                end
                ST_CHANGE: begin
                    balance <= '0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 SHALL take parameter N_ITEMS, default 8: number of product lanes.
REQ-002 SHALL take parameter SLOT_DEPTH, default 16: maximum units per lane.
REQ-003 SHALL take parameter COST_W, default 16: width in cents of cost, balance and change.
REQ-004 SHALL derive localparams IDX_W = $clog2(N_ITEMS) and CNT_W = $clog2(SLOT_DEPTH+1).
REQ-005 SHALL have port clk, input, 1: clock.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port coin, input, coin_t: coin code; NONE means no coin.
REQ-008 SHALL have port sel_valid, input, 1: one-cycle purchase request.
REQ-009 SHALL have port sel_item, input, IDX_W: lane requested.
REQ-010 SHALL have port cancel, input, 1: refund request.
REQ-011 SHALL have ports sup_valid (in, 1), sup_item (in, IDX_W), sup_count (in, CNT_W) and sup_cost (in, COST_W): supplier restock and price write.
REQ-012 SHALL have port sup_ready, output, 1: restock accepted this cycle.
REQ-013 SHALL have port vend_valid, output, 1: one-cycle dispense pulse.
REQ-014 SHALL have port vend_item, output, IDX_W: lane being dispensed.
REQ-015 SHALL have ports change_valid (out, 1) and change_amt (out, COST_W): one-cycle refund pulse and refund amount.
REQ-016 SHALL have ports coin_reject (out, 1), balance (out, COST_W) and status (out, status_t).

Function
REQ-017 SHALL implement FSM states IDLE, CREDIT, VEND and CHANGE.
REQ-018 SHALL move IDLE->CREDIT on the first accepted coin.
REQ-019 SHALL move CREDIT->VEND on a successful select.
REQ-020 SHALL move VEND->CHANGE unconditionally.
REQ-021 SHALL move CREDIT->CHANGE on cancel.
REQ-022 SHALL move CHANGE->IDLE unconditionally.
REQ-023 SHALL add the coin value (NICKEL 5, DIME 10, QUARTER 25, DOLLAR 100) to balance in IDLE and CREDIT.
REQ-024 SHALL reject a coin, pulsing coin_reject and leaving balance unchanged, if balance + value exceeds 2^COST_W-1, if the FSM is in VEND or CHANGE, or if sel_valid or cancel is asserted in the same cycle.
REQ-025 SHALL give cancel priority over sel_valid in the same cycle.
REQ-026 SHALL evaluate a select in CREDIT as NO_STOCK, with no state change, when the lane stock is 0 or its cost is 0.
REQ-027 SHALL evaluate a select in CREDIT as LOW_FUNDS, with no state change, when balance < cost.
REQ-028 SHALL otherwise latch the lane and enter VEND.
REQ-029 SHALL, in VEND, assert vend_valid and vend_item for one cycle, decrement stock by 1 and subtract cost from balance.
REQ-030 SHALL, in CHANGE, assert change_valid for one cycle with change_amt = balance, and clear balance to 0.
REQ-031 SHALL have latency: select at cycle t gives vend_valid at t+1 and change_valid at t+2; cancel at t gives change_valid at t+1.
REQ-032 SHALL ignore sel_valid outside CREDIT.
REQ-033 SHALL accept supplier writes only in IDLE; sup_ready is combinational on sup_valid in IDLE.
REQ-034 SHALL hold sup_ready low in all other states, with the write dropped.
REQ-035 SHALL, on an accepted write with stock + sup_count <= SLOT_DEPTH, update both stock and cost.
REQ-036 SHALL, on an accepted write with stock + sup_count > SLOT_DEPTH, leave stock and cost unchanged and report RESTOCK_ERR.
REQ-037 SHALL compute stock arithmetic at CNT_W+1 bits.
REQ-038 SHALL register status with values IDLE, CREDIT, VENDED, NO_STOCK, LOW_FUNDS, REFUND and RESTOCK_ERR.
REQ-039 SHALL hold status until the next event.

Reset
REQ-040 SHALL, on rst, set state IDLE, balance 0, all stock 0, all costs 0 and status IDLE.
REQ-041 SHALL, on rst, drive all pulse outputs 0 and vend_item/change_amt 0.
REQ-042 SHALL discard any credit or in-flight vend on rst mid-transaction, with no change pulse.

Structure
REQ-043 SHALL place coin_t, status_t, state_t and the coin value function in vm2002_pkg.
REQ-044 SHALL use one sub-module, vend_inventory: per-lane stock and cost register arrays with restock check, read port and decrement port.

Verification
REQ-045 SHALL cover: restock lane 2 with count 5 and cost 75 in IDLE -> sup_ready=1, stock[2]=5.
REQ-046 SHALL cover: then restock lane 2 with count 12 -> stock stays 5, status RESTOCK_ERR.
REQ-047 SHALL cover: coins DOLLAR then QUARTER, then select lane 2 -> balance=125, vend_valid at t+1 with vend_item=2, change_valid at t+2 with change_amt=50, stock[2]=4, state IDLE.
REQ-048 SHALL cover: insert DIME, select a lane costing 75 -> status LOW_FUNDS, balance stays 10; then cancel -> change_amt=10 next cycle.
REQ-049 SHALL cover: select an empty lane with balance 100 -> NO_STOCK, balance 100; coin in the same cycle as the select -> coin_reject=1.
REQ-050 SHALL cover: rst asserted in VEND -> no change pulse, balance 0, state IDLE; supplier write during CREDIT -> sup_ready=0.
